three_way_switch: RTL and testbench

- Three-way light controller: three independent wall-switch inputs drive one lamp output.
- Flipping any single switch toggles the lamp.
- Core function is f = x1 XOR x2 XOR x3, evaluated on synchronized, debounced copies of the raw switch inputs and delivered as a registered output.
- Sits at the board-I/O boundary; the raw switch inputs are asynchronous to clk.

---
 rtl/three_way_switch.sv | 90 +++++++++
 tb/tb_three_way_switch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/three_way_switch.sv
// three_way_switch: lamp output is the parity of three synchronized, debounced switch inputs.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clk edges from a clean input change to f; free-running, no backpressure.
// Optional THREE_WAY_TOGGLE_CNT_EN adds toggle_cnt, a wrapping 16-bit count of f transitions since reset.
module three_way_switch #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x1,
    input  logic        x2,
    input  logic        x3,
    output logic        f
`ifdef THREE_WAY_TOGGLE_CNT_EN
    ,
    output logic [15:0] toggle_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       sync_q [SYNC_STAGES];
    logic [2:0]       s;
    logic [2:0]       d_q;
    logic [2:0]       d_next;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_next [3];
    logic             f_next;

    assign s = sync_q[SYNC_STAGES-1];

    // Plain flop chain per input; bit i of each stage belongs to one switch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= {x3, x2, x1};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        d_next = d_q;
        for (int i = 0; i < 3; i++) begin
            cnt_next[i] = '0;
            if (s[i] != d_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    d_next[i] = s[i];
                end else begin
                    cnt_next[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
        // f is registered from the accepted values so it moves on the same edge as d.
        f_next = ^d_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= '0;
            f   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            d_q <= d_next;
            f   <= f_next;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_next[i];
            end
        end
    end

`ifdef THREE_WAY_TOGGLE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_cnt <= '0;
        end else if (f_next != f) begin
            toggle_cnt <= toggle_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_three_way_switch.sv
// Bench for three_way_switch: truth-table vectors, hand-written corner sequences and random
// stimulus, all checked against a sliding-window model of synchronizer plus debounce.
module tb_three_way_switch;

    localparam int S  = 2;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        x1  = 1'b0;
    logic        x2  = 1'b0;
    logic        x3  = 1'b0;
    logic        f;
`ifdef THREE_WAY_TOGGLE_CNT_EN
    logic [15:0] toggle_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    three_way_switch #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .x1 (x1),
        .x2 (x2),
        .x3 (x3),
        .f  (f)
`ifdef THREE_WAY_TOGGLE_CNT_EN
        ,
        .toggle_cnt(toggle_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a switch's accepted value flips once the last DC samples that have
    // crossed the S-stage synchronizer all disagree with it. Sample k reaches the
    // debounce comparison at edge k+S.
    bit          hist [3][$];
    logic [2:0]  m_d   = '0;
    logic        m_f   = 1'b0;
    logic [15:0] m_tog = '0;

    always @(posedge clk or posedge rst) begin
        logic [2:0] raw;
        logic [2:0] nd;
        bit         all_diff;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                hist[i].delete();
                repeat (S + DC) hist[i].push_back(1'b0);
            end
            m_d   <= '0;
            m_f   <= 1'b0;
            m_tog <= '0;
        end else begin
            raw = {x3, x2, x1};
            for (int i = 0; i < 3; i++) begin
                hist[i].push_back(raw[i]);
                void'(hist[i].pop_front());
                all_diff = 1'b1;
                for (int j = 0; j < DC; j++) begin
                    if (hist[i][j] == m_d[i]) all_diff = 1'b0;
                end
                nd[i] = all_diff ? ~m_d[i] : m_d[i];
            end
            m_d <= nd;
            m_f <= ^nd;
            if ((^nd) != m_f) m_tog <= m_tog + 16'd1;
        end
    end

    always @(negedge clk) begin
        check("model_f", 16'(f), 16'(m_f));
`ifdef THREE_WAY_TOGGLE_CNT_EN
        check("model_toggle_cnt", toggle_cnt, m_tog);
`endif
    end

    typedef struct {
        logic [2:0] x;
        logic       f_exp;
    } vec_t;

    vec_t tbl [8];

    task automatic drive(input logic [2:0] v);
        @(posedge clk);
        #1;
        {x1, x2, x3} = v;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [7:0]  tt;
        logic        prev;
        logic [15:0] exp_toggles;

        // f for (x1,x2,x3) = 000..111, index = {x1,x2,x3}
        tt = 8'b1001_0110;
        for (int i = 0; i < 8; i++) begin
            tbl[i].x     = 3'(i);
            tbl[i].f_exp = tt[i];
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_f", 16'(f), 16'd0);
`ifdef THREE_WAY_TOGGLE_CNT_EN
        check("reset_toggle_cnt", toggle_cnt, 16'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // Truth-table sweep with exact latency: old value after 5 edges, new after the 6th.
        prev        = 1'b0;
        exp_toggles = '0;
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].x);
            repeat (5) @(posedge clk);
            @(negedge clk);
            check("tt_before", 16'(f), 16'(prev));
            @(posedge clk);
            @(negedge clk);
            check("tt_latency", 16'(f), 16'(tbl[i].f_exp));
            repeat (13) @(posedge clk);
            @(negedge clk);
            check("tt_settled", 16'(f), 16'(tbl[i].f_exp));
            if (tbl[i].f_exp != prev) exp_toggles++;
            prev = tbl[i].f_exp;
        end
`ifdef THREE_WAY_TOGGLE_CNT_EN
        check("sweep_toggle_cnt", toggle_cnt, exp_toggles);
`endif

        // Asynchronous reset between edges while f=1.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_f", 16'(f), 16'd0);
`ifdef THREE_WAY_TOGGLE_CNT_EN
        check("async_rst_toggle_cnt", toggle_cnt, 16'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // Glitch rejection: three synchronized samples high must not be accepted.
        drive(3'b000);
        do_reset();
        drive(3'b010);
        repeat (2) @(posedge clk);
        drive(3'b000);
        repeat (10) begin
            @(negedge clk);
            check("glitch_hold", 16'(f), 16'd0);
        end
        drive(3'b010);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("glitch_before", 16'(f), 16'd0);
        @(posedge clk);
        @(negedge clk);
        check("glitch_accept", 16'(f), 16'd1);

        // Two switches flipping together: f must not move at all.
        drive(3'b100);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("simul_start", 16'(f), 16'd1);
        drive(3'b111);
        repeat (12) begin
            @(negedge clk);
            check("simul_hold", 16'(f), 16'd1);
        end

        // Reset mid-debounce, x1 held high; full latency again after release.
        drive(3'b000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("midrst_start", 16'(f), 16'd0);
        drive(3'b100);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_hold", 16'(f), 16'd0);
            @(posedge clk);
        end
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("midrst_before", 16'(f), 16'd0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_latency", 16'(f), 16'd1);

        // Random switch activity, including short glitches and occasional resets.
        repeat (300) begin
            drive(3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 7)) @(posedge clk);
            if ($urandom_range(0, 49) == 0) do_reset();
        end
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
